// File: rtl/datapath_sequencer.sv
// datapath_sequencer: Moore control FSM sequencing register-file/ALU datapath loads per instruction.
// Define DPSEQ_ILLEGAL_TRAP_EN to trap illegal instructions in ERR until reset.
module datapath_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic       s,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    output logic [2:0] nsel,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       asel,
    output logic       bsel,
    output logic [1:0] vsel,
    output logic       write,
    output logic       w,
    output logic       err,
    output logic [7:0] icount
);
    typedef enum logic [2:0] {WAIT, DECODE, GET_A, GET_B, COMPUTE, WRITE_IMM, WRITE_REG, ERR} state_t;
`ifdef DPSEQ_ILLEGAL_TRAP_EN
    localparam state_t ILL = ERR;
`else
    localparam state_t ILL = WAIT;
`endif
    state_t state, state_n;
    logic [2:0] opc_q;
    logic [1:0] op_q;
    logic is_mov, is_alu, is_cmp, legal, one_src, retire;
    assign is_mov  = opc_q == 3'b110;
    assign is_alu  = opc_q == 3'b101;
    assign is_cmp  = is_alu && op_q == 2'b01;
    assign legal   = is_alu || (is_mov && !op_q[0]);
    // MOV Rd,Rm and MVN take only the B operand, so they skip GET_A
    assign one_src = (is_mov && op_q == 2'b00) || (is_alu && op_q == 2'b11);
    assign retire  = state_n == WAIT && (state == WRITE_IMM || state == WRITE_REG || state == COMPUTE);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= WAIT;
            opc_q  <= 3'b000;
            op_q   <= 2'b00;
            icount <= 8'd0;
        end else begin
            state <= state_n;
            if (state == WAIT && s) begin
                opc_q <= opcode;
                op_q  <= op;
            end
            if (retire)
                icount <= icount + 8'd1;
        end
    end
    always_comb begin
        state_n = state;
        case (state)
            WAIT:      state_n = s ? DECODE : WAIT;
            DECODE:    state_n = !legal ? ILL : (is_mov && op_q[1]) ? WRITE_IMM : one_src ? GET_B : GET_A;
            GET_A:     state_n = GET_B;
            GET_B:     state_n = COMPUTE;
            COMPUTE:   state_n = is_cmp ? WAIT : WRITE_REG;
            WRITE_IMM: state_n = WAIT;
            WRITE_REG: state_n = WAIT;
            default:   state_n = state;
        endcase
    end
    assign nsel  = (state == GET_A || state == WRITE_IMM) ? 3'b100 :
                   state == GET_B ? 3'b001 :
                   state == WRITE_REG ? 3'b010 : 3'b000;
    assign loada = state == GET_A;
    assign loadb = state == GET_B;
    assign loadc = state == COMPUTE && !is_cmp;
    assign loads = state == COMPUTE && is_cmp;
    assign asel  = state == COMPUTE && one_src;
    assign bsel  = 1'b0;
    assign vsel  = {1'b0, state == WRITE_IMM};
    assign write = state == WRITE_IMM || state == WRITE_REG;
    assign w     = state == WAIT;
    assign err   = state == ERR;
endmodule

// File: tb/tb_datapath_sequencer.sv
// tb_datapath_sequencer: directed bench with an instruction-schedule model checked every cycle.
module tb_datapath_sequencer;
    typedef logic [13:0] vec_t;
    typedef vec_t vec_q_t[$];
    // vector = {nsel, loada, loadb, loadc, loads, asel, bsel, vsel, write, w, err}
    localparam vec_t IDLE = {3'b000, 5'b00000, 1'b0, 2'b00, 3'b010};
    localparam vec_t DEC  = {3'b000, 5'b00000, 1'b0, 2'b00, 3'b000};
    localparam vec_t GA   = {3'b100, 5'b10000, 1'b0, 2'b00, 3'b000};
    localparam vec_t GB   = {3'b001, 5'b01000, 1'b0, 2'b00, 3'b000};
    localparam vec_t CA0  = {3'b000, 5'b00100, 1'b0, 2'b00, 3'b000};
    localparam vec_t CA1  = {3'b000, 5'b00101, 1'b0, 2'b00, 3'b000};
    localparam vec_t CCMP = {3'b000, 5'b00010, 1'b0, 2'b00, 3'b000};
    localparam vec_t WIMM = {3'b100, 5'b00000, 1'b0, 2'b01, 3'b100};
    localparam vec_t WREG = {3'b010, 5'b00000, 1'b0, 2'b00, 3'b100};
    localparam vec_t ERRV = {3'b000, 5'b00000, 1'b0, 2'b00, 3'b001};
`ifdef DPSEQ_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    logic clk = 1'b0, reset = 1'b0, s = 1'b0;
    logic [2:0] opcode = 3'b000;
    logic [1:0] op = 2'b00;
    logic [2:0] nsel;
    logic loada, loadb, loadc, loads, asel, bsel, write, w, err;
    logic [1:0] vsel;
    logic [7:0] icount;
    int compared = 0, mismatched = 0;
    vec_t q[$];
    bit m_legal = 1'b0, trapped = 1'b0;
    logic [7:0] mcount = 8'd0;
    always #5 clk = ~clk;
    datapath_sequencer dut (
        .clk(clk), .reset(reset), .s(s), .opcode(opcode), .op(op), .nsel(nsel),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads), .asel(asel), .bsel(bsel),
        .vsel(vsel), .write(write), .w(w), .err(err), .icount(icount)
    );
    function automatic vec_q_t sched(input logic [2:0] oc, input logic [1:0] o);
        vec_q_t r;
        case ({oc, o})
            5'b110_10: r = '{DEC, WIMM};
            5'b110_00: r = '{DEC, GB, CA1, WREG};
            5'b101_00: r = '{DEC, GA, GB, CA0, WREG};
            5'b101_10: r = '{DEC, GA, GB, CA0, WREG};
            5'b101_01: r = '{DEC, GA, GB, CCMP};
            5'b101_11: r = '{DEC, GB, CA1, WREG};
            default:   r = '{DEC};
        endcase
        return r;
    endfunction
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, exp);
        end
    endtask
    task automatic go(input logic [2:0] oc, input logic [1:0] o);
        opcode = oc;
        op = o;
        s = 1'b1;
        @(negedge clk);
        s = 1'b0;
    endtask
    task automatic adv(input int n);
        repeat (n) @(negedge clk);
    endtask
    // Model: the instruction's cycle schedule is queued on accept and consumed one entry per clock
    initial forever begin
        @(posedge clk or negedge reset);
        if (!reset) begin
            q.delete();
            trapped = 1'b0;
            mcount = 8'd0;
        end else if (!trapped) begin
            if (q.size() == 0) begin
                if (s) begin
                    q = sched(opcode, op);
                    m_legal = q.size() > 1;
                end
            end else begin
                void'(q.pop_front());
                if (q.size() == 0) begin
                    if (m_legal) mcount = mcount + 8'd1;
                    else trapped = TRAP;
                end
            end
        end
    end
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    initial begin
        vec_t expv;
        fork
            forever begin
                @(negedge clk);
                expv = trapped ? ERRV : (q.size() != 0 ? q[0] : IDLE);
                chk("cycle_vec", 32'({nsel, loada, loadb, loadc, loads, asel, bsel, vsel, write, w, err}), 32'(expv));
                chk("cycle_icount", 32'(icount), 32'(mcount));
            end
        join_none
        #12;
        chk("rst_w", 32'(w), 1);
        chk("rst_err", 32'(err), 0);
        chk("rst_icount", 32'(icount), 0);
        chk("rst_nsel", 32'(nsel), 0);
        @(negedge clk);
        reset = 1'b1;
        adv(1);
        go(3'b110, 2'b10);
        adv(1);
        chk("movi_write", 32'(write), 1);
        chk("movi_nsel", 32'(nsel), 4);
        chk("movi_vsel", 32'(vsel), 1);
        adv(1);
        chk("movi_w", 32'(w), 1);
        chk("movi_icount", 32'(icount), 1);
        go(3'b101, 2'b00);
        opcode = 3'b111;
        op = 2'b11;
        adv(1);
        chk("add_loada", 32'(loada), 1);
        chk("add_nsel_a", 32'(nsel), 4);
        adv(1);
        chk("add_loadb", 32'(loadb), 1);
        chk("add_nsel_b", 32'(nsel), 1);
        adv(1);
        chk("add_loadc", 32'(loadc), 1);
        adv(1);
        chk("add_write", 32'(write), 1);
        chk("add_nsel_d", 32'(nsel), 2);
        adv(1);
        chk("add_w", 32'(w), 1);
        chk("add_icount", 32'(icount), 2);
        go(3'b101, 2'b01);
        adv(3);
        chk("cmp_loads", 32'(loads), 1);
        chk("cmp_loadc", 32'(loadc), 0);
        adv(1);
        chk("cmp_w", 32'(w), 1);
        chk("cmp_icount", 32'(icount), 3);
        go(3'b110, 2'b00);
        adv(4);
        chk("movr_w", 32'(w), 1);
        go(3'b101, 2'b11);
        adv(4);
        chk("mvn_w", 32'(w), 1);
        go(3'b101, 2'b10);
        adv(5);
        chk("and_w", 32'(w), 1);
        chk("and_icount", 32'(icount), 6);
`ifdef DPSEQ_ILLEGAL_TRAP_EN
        go(3'b111, 2'b00);
        adv(1);
        chk("trap_err", 32'(err), 1);
        chk("trap_w", 32'(w), 0);
        s = 1'b1;
        adv(10);
        chk("trap_hold_err", 32'(err), 1);
        chk("trap_hold_w", 32'(w), 0);
        chk("trap_icount", 32'(icount), 6);
        s = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("trap_clr_err", 32'(err), 0);
        chk("trap_clr_w", 32'(w), 1);
        @(negedge clk);
        reset = 1'b1;
        adv(1);
        go(3'b110, 2'b11);
        adv(1);
        chk("trap_110_11", 32'(err), 1);
        #2 reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        adv(1);
`else
        go(3'b111, 2'b00);
        adv(1);
        chk("ill_w", 32'(w), 1);
        chk("ill_icount", 32'(icount), 6);
        go(3'b110, 2'b01);
        adv(1);
        chk("ill_110_01", 32'(w), 1);
        go(3'b110, 2'b11);
        adv(1);
        chk("ill_110_11", 32'(icount), 6);
`endif
        go(3'b110, 2'b10);
        adv(2);
        go(3'b101, 2'b00);
        adv(2);
        #2 reset = 1'b0;
        #1;
        chk("arst_loadb", 32'(loadb), 0);
        chk("arst_nsel", 32'(nsel), 0);
        chk("arst_write", 32'(write), 0);
        chk("arst_w", 32'(w), 1);
        chk("arst_icount", 32'(icount), 0);
        @(negedge clk);
        reset = 1'b1;
        adv(6);
        chk("arst_after_icount", 32'(icount), 0);
        opcode = 3'b110;
        op = 2'b10;
        s = 1'b1;
        for (int i = 0; i < 256; i++) begin
            for (int k = 0; k < 10 && !w; k++) @(negedge clk);
            if (i == 255) chk("wrap_pre_icount", 32'(icount), 255);
            if (!w) chk("wrap_wait_w", 32'(w), 1);
            @(negedge clk);
        end
        s = 1'b0;
        adv(3);
        chk("wrap_icount", 32'(icount), 0);
        chk("wrap_w", 32'(w), 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
